display_link_ctrl: RTL and testbench

DISPLAY_LINK_CTRL -- requirements
Module: display_link_ctrl

---
 rtl/display_link_pkg.sv | 17 +
 rtl/display_debounce.sv | 53 +++++
 rtl/display_link_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_display_link_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/display_link_pkg.sv
// display_link_pkg
//   Shared definitions for the display link controller: the state register
//   width and the state encodings that also appear on o_state.
package display_link_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_HPD  = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_ACTIVE    = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

endpackage

// File: rtl/display_debounce.sv
// display_debounce
//   Two-flop synchronizer followed by a persistence filter. The filtered level
//   starts at 0 and only follows the synchronized input after it has differed
//   from the current level for COUNT consecutive clock cycles.
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_async  : asynchronous input to be filtered
//   o_level  : synchronized, debounced level
module display_debounce #(
    parameter int COUNT = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level
);

    localparam int CNT_W = (COUNT < 2) ? 1 : $clog2(COUNT + 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], i_async};
        level_d = level_q;
        cnt_d   = '0;
        // Any cycle where the input agrees with the current level restarts the count.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(COUNT - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;

endmodule

// File: rtl/display_link_ctrl.sv
// display_link_ctrl
//   Bring-up sequencer for a display output link: waits for a debounced
//   hot-plug, a stable pixel-clock lock, then releases the pixel path and
//   removes blanking after a few frames. Lock loss or a missing vsync drops
//   into FAULT, which retries lock after a fixed delay.
// Ports
//   i_clk, i_rst_n  : clock and asynchronous active-low reset
//   i_enable        : link enable (synchronous)
//   i_hpd           : hot-plug detect (asynchronous)
//   i_clk_lock      : pixel-clock generator lock (asynchronous)
//   i_vs            : vertical sync, active high (asynchronous)
//   o_rst_pix       : reset for timing generator / TMDS path
//   o_tx_en         : serializer enable
//   o_blank         : force blanking
//   o_link_up       : link is ACTIVE
//   o_state         : current state encoding
//   o_fault_count   : saturating count of FAULT entries
module display_link_ctrl
    import display_link_pkg::*;
#(
    parameter int HPD_DEBOUNCE  = 1000,
    parameter int LOCK_CYCLES   = 256,
    parameter int BLANK_FRAMES  = 2,
    parameter int FRAME_TIMEOUT = 2000000,
    parameter int RETRY_CYCLES  = 1000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_enable,
    input  logic         i_hpd,
    input  logic         i_clk_lock,
    input  logic         i_vs,
    output logic         o_rst_pix,
    output logic         o_tx_en,
    output logic         o_blank,
    output logic         o_link_up,
    output logic [2:0]   o_state,
    output logic [7:0]   o_fault_count
);

    localparam int LOCK_W  = $clog2(LOCK_CYCLES + 1);
    localparam int FRM_W   = $clog2(BLANK_FRAMES + 1);
    localparam int TO_W    = $clog2(FRAME_TIMEOUT + 1);
    localparam int RETRY_W = $clog2(RETRY_CYCLES + 1);

    state_e               state_q, state_d;
    logic [1:0]           lock_sync_q, lock_sync_d;
    logic [1:0]           vs_sync_q, vs_sync_d;
    logic                 vs_prev_q, vs_prev_d;
    logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [FRM_W-1:0]     frm_cnt_q, frm_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic [7:0]           fault_cnt_q, fault_cnt_d;
    logic                 rst_pix_q, rst_pix_d;
    logic                 tx_en_q, tx_en_d;
    logic                 blank_q, blank_d;
    logic                 link_up_q, link_up_d;

    logic                 hpd_db;
    logic                 lock_s;
    logic                 frame_edge;
    logic                 pix_on;

    display_debounce #(
        .COUNT   (HPD_DEBOUNCE)
    ) u_hpd_debounce (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_hpd),
        .o_level (hpd_db)
    );

    assign lock_s     = lock_sync_q[1];
    assign frame_edge = vs_sync_q[1] & ~vs_prev_q;

    always_comb begin
        lock_sync_d = {lock_sync_q[0], i_clk_lock};
        vs_sync_d   = {vs_sync_q[0], i_vs};
        vs_prev_d   = vs_sync_q[1];

        state_d     = state_q;
        // Counters read as zero outside their own state, so each starts clean on entry.
        lock_cnt_d  = '0;
        frm_cnt_d   = '0;
        to_cnt_d    = '0;
        retry_cnt_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_enable) state_d = ST_WAIT_HPD;
            end
            ST_WAIT_HPD: begin
                if (hpd_db) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                lock_cnt_d = lock_s ? lock_cnt_q + LOCK_W'(1) : '0;
                if (lock_cnt_d == LOCK_W'(LOCK_CYCLES)) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                frm_cnt_d = frm_cnt_q;
                if (frame_edge) begin
                    frm_cnt_d = frm_cnt_q + FRM_W'(1);
                    if (frm_cnt_d == FRM_W'(BLANK_FRAMES)) state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                state_d = ST_ACTIVE;
            end
            ST_FAULT: begin
                retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                if (retry_cnt_d == RETRY_W'(RETRY_CYCLES)) state_d = ST_WAIT_LOCK;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame watchdog and lock monitor override the per-state transitions,
        // so lock loss beats a coincident frame edge.
        if (state_q == ST_RELEASE || state_q == ST_ACTIVE) begin
            to_cnt_d = frame_edge ? '0 : to_cnt_q + TO_W'(1);
            if (!lock_s || to_cnt_d == TO_W'(FRAME_TIMEOUT)) state_d = ST_FAULT;
        end

        if (!hpd_db && (state_q inside {ST_WAIT_LOCK, ST_RELEASE, ST_ACTIVE, ST_FAULT})) begin
            state_d = ST_WAIT_HPD;
        end

        if (!i_enable) state_d = ST_IDLE;

        fault_cnt_d = fault_cnt_q;
        if (state_d == ST_FAULT && state_q != ST_FAULT && fault_cnt_q != 8'hFF) begin
            fault_cnt_d = fault_cnt_q + 8'd1;
        end

        // Outputs are decoded from the next state so they line up with o_state.
        pix_on    = (state_d == ST_RELEASE) || (state_d == ST_ACTIVE);
        rst_pix_d = ~pix_on;
        tx_en_d   = pix_on;
        blank_d   = (state_d != ST_ACTIVE);
        link_up_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            lock_sync_q <= '0;
            vs_sync_q   <= '0;
            vs_prev_q   <= 1'b0;
            lock_cnt_q  <= '0;
            frm_cnt_q   <= '0;
            to_cnt_q    <= '0;
            retry_cnt_q <= '0;
            fault_cnt_q <= '0;
            rst_pix_q   <= 1'b1;
            tx_en_q     <= 1'b0;
            blank_q     <= 1'b1;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_sync_q <= lock_sync_d;
            vs_sync_q   <= vs_sync_d;
            vs_prev_q   <= vs_prev_d;
            lock_cnt_q  <= lock_cnt_d;
            frm_cnt_q   <= frm_cnt_d;
            to_cnt_q    <= to_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            fault_cnt_q <= fault_cnt_d;
            rst_pix_q   <= rst_pix_d;
            tx_en_q     <= tx_en_d;
            blank_q     <= blank_d;
            link_up_q   <= link_up_d;
        end
    end

    assign o_state       = state_q;
    assign o_rst_pix     = rst_pix_q;
    assign o_tx_en       = tx_en_q;
    assign o_blank       = blank_q;
    assign o_link_up     = link_up_q;
    assign o_fault_count = fault_cnt_q;

endmodule

// File: tb/tb_display_link_ctrl.sv
// tb_display_link_ctrl
//   Directed bench for display_link_ctrl with small timing parameters.
//   A table of {inputs, hold cycles, expected state/fault count} rows walks
//   the link up, through lock loss, a lock glitch, watchdog timeout, enable
//   drop and a coincident lock-loss/frame-edge. Hand sequences then cover
//   fault-count saturation, HPD glitch filtering and asynchronous reset.
module tb_display_link_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en, hpd, lock, vs;
    logic       rst_pix, tx_en, blank, link_up;
    logic [2:0] state;
    logic [7:0] fault_count;

    int n_vec = 0;
    int n_err = 0;

    display_link_ctrl #(
        .HPD_DEBOUNCE  (4),
        .LOCK_CYCLES   (8),
        .BLANK_FRAMES  (2),
        .FRAME_TIMEOUT (100),
        .RETRY_CYCLES  (10)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en),
        .i_hpd         (hpd),
        .i_clk_lock    (lock),
        .i_vs          (vs),
        .o_rst_pix     (rst_pix),
        .o_tx_en       (tx_en),
        .o_blank       (blank),
        .o_link_up     (link_up),
        .o_state       (state),
        .o_fault_count (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic en;
        logic hpd;
        logic lock;
        logic vs;
        int   cyc;
        int   st;
        int   fc;
    } vec_t;

    vec_t tbl [34];

    function automatic vec_t mk(input logic e, input logic h, input logic l, input logic v,
                                input int c, input int s, input int f);
        vec_t r;
        r.en = e; r.hpd = h; r.lock = l; r.vs = v;
        r.cyc = c; r.st = s; r.fc = f;
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs: pixel path runs only in RELEASE(3)/ACTIVE(4), unblanked only in ACTIVE.
    task automatic chk_all(input string tag, input int st, input int fc);
        chk({tag, ".state"},   int'(state),       st);
        chk({tag, ".rst_pix"}, int'(rst_pix),     (st == 3 || st == 4) ? 0 : 1);
        chk({tag, ".tx_en"},   int'(tx_en),       (st == 3 || st == 4) ? 1 : 0);
        chk({tag, ".blank"},   int'(blank),       (st == 4) ? 0 : 1);
        chk({tag, ".link_up"}, int'(link_up),     (st == 4) ? 1 : 0);
        chk({tag, ".fcount"},  int'(fault_count), fc);
    endtask

    initial begin
        //                en hpd lock vs cyc  st fc
        tbl[0]  = mk(1, 1, 1, 0,  1, 1, 0);
        tbl[1]  = mk(1, 1, 1, 0,  5, 1, 0);
        tbl[2]  = mk(1, 1, 1, 0,  1, 2, 0);
        tbl[3]  = mk(1, 1, 1, 0,  7, 2, 0);
        tbl[4]  = mk(1, 1, 1, 0,  1, 3, 0);
        tbl[5]  = mk(1, 1, 1, 0, 20, 3, 0);
        tbl[6]  = mk(1, 1, 1, 1,  2, 3, 0);
        tbl[7]  = mk(1, 1, 1, 0, 38, 3, 0);
        tbl[8]  = mk(1, 1, 1, 1,  2, 3, 0);
        tbl[9]  = mk(1, 1, 1, 1,  1, 4, 0);
        tbl[10] = mk(1, 1, 1, 0, 10, 4, 0);
        tbl[11] = mk(1, 1, 0, 0,  1, 4, 0);
        tbl[12] = mk(1, 1, 1, 0,  1, 4, 0);
        tbl[13] = mk(1, 1, 1, 0,  1, 5, 1);
        tbl[14] = mk(1, 1, 1, 0,  9, 5, 1);
        tbl[15] = mk(1, 1, 1, 0,  1, 2, 1);
        tbl[16] = mk(1, 1, 1, 0,  3, 2, 1);
        tbl[17] = mk(1, 1, 0, 0,  1, 2, 1);
        tbl[18] = mk(1, 1, 1, 0,  1, 2, 1);
        tbl[19] = mk(1, 1, 1, 0,  8, 2, 1);
        tbl[20] = mk(1, 1, 1, 0,  1, 3, 1);
        tbl[21] = mk(1, 1, 1, 1,  5, 3, 1);
        tbl[22] = mk(1, 1, 1, 0,  5, 3, 1);
        tbl[23] = mk(1, 1, 1, 1,  3, 4, 1);
        tbl[24] = mk(1, 1, 1, 0, 99, 4, 1);
        tbl[25] = mk(1, 1, 1, 0,  1, 5, 2);
        tbl[26] = mk(0, 1, 1, 0,  1, 0, 2);
        tbl[27] = mk(1, 1, 1, 0,  1, 1, 2);
        tbl[28] = mk(1, 1, 1, 0,  1, 2, 2);
        tbl[29] = mk(1, 1, 1, 0,  8, 3, 2);
        tbl[30] = mk(1, 1, 1, 1,  4, 3, 2);
        tbl[31] = mk(1, 1, 1, 0,  4, 3, 2);
        tbl[32] = mk(1, 1, 0, 1,  3, 5, 3);
        tbl[33] = mk(1, 1, 1, 0, 10, 2, 3);

        rst_n = 1'b0;
        en = 1'b0; hpd = 1'b0; lock = 1'b0; vs = 1'b0;
        step(3);
        chk_all("reset", 0, 0);
        rst_n = 1'b1;
        step(3);
        chk_all("idle_disabled", 0, 0);

        for (int i = 0; i < 34; i++) begin
            en   = tbl[i].en;
            hpd  = tbl[i].hpd;
            lock = tbl[i].lock;
            vs   = tbl[i].vs;
            step(tbl[i].cyc);
            chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].fc);
        end

        // Repeated watchdog faults (WAIT_LOCK 8 + RELEASE 100 + FAULT 10 per
        // loop) push the fault counter well past 255 entries.
        en = 1'b1; hpd = 1'b1; lock = 1'b1; vs = 1'b0;
        step(35400);
        chk("fault_saturate", int'(fault_count), 255);

        // Fresh start from reset, inputs already asserted.
        rst_n = 1'b0;
        #1;
        chk_all("reset_again", 0, 0);
        step(2);
        rst_n = 1'b1;
        step(15);
        chk_all("hs_release", 3, 0);

        // 3-cycle HPD glitch is filtered.
        step(5);
        hpd = 1'b0;
        step(3);
        hpd = 1'b1;
        step(12);
        chk_all("hpd_glitch3", 3, 0);

        // 4-cycle-plus HPD low is accepted and forces WAIT_HPD.
        hpd = 1'b0;
        step(6);
        chk_all("hpd_low_pre", 3, 0);
        step(1);
        chk_all("hpd_low_wait", 1, 0);

        // Reconnect and run two frames into ACTIVE.
        hpd = 1'b1;
        step(15);
        chk_all("reconnect_rel", 3, 0);
        vs = 1'b1;
        step(2);
        vs = 1'b0;
        step(4);
        vs = 1'b1;
        step(3);
        chk_all("reconnect_act", 4, 0);

        // Asynchronous reset mid-cycle in ACTIVE; outputs must drop before the next edge.
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0);
        #2;
        rst_n = 1'b1;
        step(1);
        chk_all("after_reset", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
